// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// baud divider and mid-bit helpers, data width.
package uart_rx_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        BREAK  = ST_BREAK
    } uart_rx_state_e;

    // Clock cycles per oversample tick; never below one so tick stays defined.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        int d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int calc_mid(input int oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, shared by
// the UART receiver and transmitter.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for
// 8E1 with an even-parity check and active parity_err.
module uart_rx_oversample
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int MID = calc_mid(OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(DATA_W);

    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SC_LO   = SCW'(MID - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(MID);
    localparam logic [SCW-1:0] SC_HI   = SCW'(MID + 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_W - 1);

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic              rx_meta_q, rx_meta_d;
    logic              rxs_q, rxs_d;
    logic [2:0]        state_q, state_d;
    logic [SCW-1:0]    sc_q, sc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              s_lo_q, s_lo_d;
    logic              s_mid_q, s_mid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    logic [SCW-1:0] sc_inc;
    logic           eval;
    logic           bit_v;
    logic           deliver;

    // sc_inc is the post-tick count; the third vote is the live sample.
    assign sc_inc = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
    assign eval   = tick && (sc_inc == SC_HI);
    assign bit_v  = (s_lo_q & s_mid_q) | (s_lo_q & rxs_q) | (s_mid_q & rxs_q);

    always_comb begin
        rx_meta_d   = rx;
        rxs_d       = rx_meta_q;
        state_d     = state_q;
        sc_d        = sc_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        s_lo_d      = s_lo_q;
        s_mid_d     = s_mid_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (tick) begin
            sc_d = sc_inc;
            if (sc_inc == SC_LO) begin
                s_lo_d = rxs_q;
            end
            if (sc_inc == SC_MID) begin
                s_mid_d = rxs_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    sc_d    = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (eval) begin
                    idx_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    state_d = bit_v ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (eval) begin
                    shift_d[idx_q] = bit_v;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (eval) begin
                    if (bit_v != (^shift_q)) begin
                        par_bad_d    = 1'b1;
                        parity_err_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (eval) begin
                    if (!bit_v) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end
`ifdef UART_RX_PARITY_EN
                    if (par_bad_q) begin
                        deliver = 1'b0;
                    end
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Holding register: a full, unconsumed byte wins over a new one.
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            sc_q        <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            s_lo_q      <= 1'b1;
            s_mid_q     <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            sc_q        <= sc_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            s_lo_q      <= s_lo_d;
            s_mid_q     <= s_mid_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed frames plus a random
// batch scored against a frame-level model of expected bytes and error pulses.
module tb_uart_rx_oversample;

    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD_RATE  = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int DIV_RAW    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BITC       = DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_EXP    = BITC * 21 / 2;
`else
    localparam int LAT_EXP    = BITC * 19 / 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_oversample #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Monitor: accepted bytes and pulse counts, sampled mid-cycle.
    logic [7:0] got_q[$];
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vcyc_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid)   vcyc_cnt++;
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    // Model state: expected bytes plus consumed-so-far bases.
    logic [7:0] exp_q[$];
    int got_base = 0, fe_base = 0, ov_base = 0, pe_base = 0, v_base = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v, input int gap);
        rx = 1'b0;
        wait_cyc(BITC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(BITC);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_v;
        wait_cyc(BITC);
`else
        if (par_v === 1'bx) rx = 1'b1;
`endif
        rx = stop_v;
        wait_cyc(BITC);
        rx = 1'b1;
        if (gap > 0) wait_cyc(gap);
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    task automatic check_bytes(input string tag);
        int n_got;
        n_got = got_q.size() - got_base;
        check_eq({tag, "_nbytes"}, n_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_got) check_eq({tag, "_byte"}, got_q[got_base + i], exp_q[i]);
        end
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag, input int fe, input int ov, input int pe);
        check_eq({tag, "_frame_err"}, fe_cnt - fe_base, fe);
        check_eq({tag, "_overrun"}, ov_cnt - ov_base, ov);
        check_eq({tag, "_parity_err"}, pe_cnt - pe_base, pe);
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        pe_base = pe_cnt;
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int lat;
        int n_fe, n_pe;

        wait_cyc(5);
        rst = 1'b0;
        check_eq("rst_data", rx_data, 8'h00);
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_parity_err", parity_err, 1'b0);
        wait_cyc(20);

        // Clean 0xA5 with ready high, plus frame-to-valid latency.
        rx_ready = 1'b1;
        v_base = vcyc_cnt;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, even_par(8'hA5), BITC);
            begin
                while (!rx_valid && lat < 3000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check_eq("clean_latency_ok", (lat >= LAT_EXP - 16) && (lat <= LAT_EXP + 32), 1'b1);
        check_eq("clean_valid_cycles", vcyc_cnt - v_base, 1);
        exp_q.push_back(8'hA5);
        check_bytes("clean");
        check_counts("clean", 0, 0, 0);

        // One-tick glitch on an idle line, then a frame to prove recovery.
        rx = 1'b0;
        wait_cyc(DIV);
        rx = 1'b1;
        v_base = vcyc_cnt;
        wait_cyc(2 * BITC);
        check_eq("glitch_valid_cycles", vcyc_cnt - v_base, 0);
        check_bytes("glitch");
        check_counts("glitch", 0, 0, 0);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, even_par(b), BITC);
        exp_q.push_back(b);
        check_bytes("post_glitch");

        // Stop bit low: frame error, no byte, next frame fine.
        v_base = vcyc_cnt;
        send_frame(8'h3C, 1'b0, even_par(8'h3C), BITC);
        check_eq("ferr_valid_cycles", vcyc_cnt - v_base, 0);
        check_bytes("ferr");
        check_counts("ferr", 1, 0, 0);
        send_frame(8'h55, 1'b1, even_par(8'h55), BITC);
        exp_q.push_back(8'h55);
        check_bytes("post_ferr");

        // Back-to-back with ready low: first byte held, second dropped.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, even_par(8'h11), 0);
        send_frame(8'h22, 1'b1, even_par(8'h22), BITC);
        check_eq("ovr_valid_held", rx_valid, 1'b1);
        check_eq("ovr_data_held", rx_data, 8'h11);
        check_counts("ovr", 0, 1, 0);
        check_bytes("ovr_none_taken");
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check_eq("ovr_valid_drop", rx_valid, 1'b0);
        wait_cyc(3);
        exp_q.push_back(8'h11);
        check_bytes("ovr_taken");
        rx_ready = 1'b1;

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, BITC);
        check_bytes("par_bad");
        check_counts("par_bad", 0, 0, 1);
        send_frame(8'h07, 1'b1, 1'b1, BITC);
        exp_q.push_back(8'h07);
        check_bytes("par_good");
        check_counts("par_good", 0, 0, 0);
`endif

        // Reset at data bit 4 while a stale byte is held.
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, even_par(8'h5A), BITC);
        check_eq("prerst_valid", rx_valid, 1'b1);
        b = {4'hF, 4'($urandom_range(0, 15))};
        fork
            send_frame(b, 1'b1, even_par(b), BITC);
            begin
                wait_cyc(BITC * 5 + BITC / 2);
                rst = 1'b1;
                wait_cyc(1);
                rst = 1'b0;
                check_eq("midrst_data", rx_data, 8'h00);
                check_eq("midrst_valid", rx_valid, 1'b0);
                check_eq("midrst_errs", {frame_err, overrun, parity_err}, 3'b000);
            end
        join
        rx_ready = 1'b1;
        wait_cyc(4);
        check_bytes("midrst_partial");
        check_counts("midrst", 0, 0, 0);
        send_frame(8'hC3, 1'b1, even_par(8'hC3), BITC);
        exp_q.push_back(8'hC3);
        check_bytes("post_rst");

        // Random batch: random bytes, gaps, stop/parity faults, ready jitter.
        n_fe = 0;
        n_pe = 0;
        begin
            bit done;
            done = 1'b0;
            fork
                begin
                    for (int f = 0; f < 20; f++) begin
                        logic bad_stop, bad_par;
                        int gap;
                        b = 8'($urandom_range(0, 255));
                        bad_stop = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
                        bad_par = ($urandom_range(0, 5) == 0);
`else
                        bad_par = 1'b0;
`endif
                        if (bad_stop) gap = BITC + $urandom_range(0, 100);
                        else if ($urandom_range(0, 3) == 0) gap = 0;
                        else gap = $urandom_range(1, 150);
                        if (bad_stop) n_fe++;
                        if (bad_par) n_pe++;
                        if (!bad_stop && !bad_par) exp_q.push_back(b);
                        send_frame(b, ~bad_stop, even_par(b) ^ bad_par, gap);
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        wait_cyc(1);
                        rx_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
        end
        rx_ready = 1'b1;
        wait_cyc(2 * BITC);
        check_bytes("rand");
        check_counts("rand", n_fe, 0, n_pe);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
